// File: rtl/alu_share_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter:
// ALU control codes, FSM state encoding and default widths.
package alu_share_arb_pkg;

   localparam int W_DEF     = 32;
   localparam int N_REQ_DEF = 2;

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLT = 4'b0111;
   localparam logic [3:0] CTRL_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle of alu_share_arb.
// rsp_ovf_o exists only when ALU_SHARE_ARB_OVF_EN is defined.
interface alu_share_arb_if
   import alu_share_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
);

   logic [N_REQ-1:0]          req_valid_i;
   logic [N_REQ-1:0]          req_ready_o;
   logic [N_REQ-1:0][3:0]     req_ctrl_i;
   logic [N_REQ-1:0][W-1:0]   req_src1_i;
   logic [N_REQ-1:0][W-1:0]   req_src2_i;
   logic [N_REQ-1:0]          rsp_valid_o;
   logic [N_REQ-1:0]          rsp_ready_i;
   logic [W-1:0]              rsp_result_o;
   logic                      rsp_zero_o;
   logic                      busy_o;
`ifdef ALU_SHARE_ARB_OVF_EN
   logic                      rsp_ovf_o;
`endif

   modport slave (
      input  req_valid_i,
      input  req_ctrl_i,
      input  req_src1_i,
      input  req_src2_i,
      input  rsp_ready_i,
      output req_ready_o,
      output rsp_valid_o,
      output rsp_result_o,
      output rsp_zero_o,
`ifdef ALU_SHARE_ARB_OVF_EN
      output rsp_ovf_o,
`endif
      output busy_o
   );

   modport master (
      output req_valid_i,
      output req_ctrl_i,
      output req_src1_i,
      output req_src2_i,
      output rsp_ready_i,
      input  req_ready_o,
      input  rsp_valid_o,
      input  rsp_result_o,
      input  rsp_zero_o,
`ifdef ALU_SHARE_ARB_OVF_EN
      input  rsp_ovf_o,
`endif
      input  busy_o
   );

endinterface

// File: rtl/alu_share_arb_rr_grant2.sv
// Two-way round-robin grant: on contention the requester
// not served last wins.
module rr_grant2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       gnt,
   output logic       any
);

   always_comb begin
      any = |valid;
      gnt = 1'b0;
      unique case (valid)
         2'b11:   gnt = ~last;
         2'b10:   gnt = 1'b1;
         default: gnt = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_share_arb.sv
// One ALU shared by two requesters, one op in flight.
// Define ALU_SHARE_ARB_OVF_EN to add the rsp_ovf_o flag.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
)(
   input logic            clk_i,
   input logic            rst_n,
   alu_share_arb_if.slave bus
);

   state_t       state;
   state_t       state_nx;
   logic [3:0]   ctrl_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [W-1:0] res_q;
   logic         zero_q;
   logic         gid_q;
   logic         last_q;
   logic         gnt;
   logic         any;
   logic         accept;
   logic         done;

   logic         sub;
   logic [W-1:0] b_eff;
   logic [W-1:0] sum;
   logic         ovf;
   logic [W-1:0] alu_res;

   rr_grant2 u_grant (
      .valid (bus.req_valid_i[1:0]),
      .last  (last_q),
      .gnt   (gnt),
      .any   (any)
   );

   assign accept = (state == ST_IDLE) && any;
   assign done   = (state == ST_RESP) && bus.rsp_ready_i[gid_q];

   always_comb begin
      state_nx        = state;
      bus.req_ready_o = '0;
      bus.rsp_valid_o = '0;
      unique case (state)
         ST_IDLE: begin
            if (any) begin
               bus.req_ready_o[gnt] = 1'b1;
               state_nx = ST_EXEC;
            end
         end
         ST_EXEC: state_nx = ST_RESP;
         ST_RESP: begin
            bus.rsp_valid_o[gid_q] = 1'b1;
            if (bus.rsp_ready_i[gid_q])
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // SUB and SLT share the inverted-operand adder path
   always_comb begin
      sub     = (ctrl_q == CTRL_SUB) || (ctrl_q == CTRL_SLT);
      b_eff   = sub ? ~b_q : b_q;
      sum     = a_q + b_eff + {{(W-1){1'b0}}, sub};
      ovf     = (a_q[W-1] == b_eff[W-1]) &&
                (sum[W-1] != a_q[W-1]);
      alu_res = '0;
      case (ctrl_q)
         CTRL_AND: alu_res = a_q & b_q;
         CTRL_OR:  alu_res = a_q | b_q;
         CTRL_ADD: alu_res = sum;
         CTRL_SUB: alu_res = sum;
         CTRL_SLT: alu_res = {{(W-1){1'b0}}, sum[W-1] ^ ovf};
         CTRL_NOR: alu_res = ~(a_q | b_q);
         default:  alu_res = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         last_q <= 1'b1;
         gid_q  <= 1'b0;
         ctrl_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            gid_q  <= gnt;
            ctrl_q <= bus.req_ctrl_i[gnt];
            a_q    <= bus.req_src1_i[gnt];
            b_q    <= bus.req_src2_i[gnt];
         end
         if (state == ST_EXEC) begin
            res_q  <= alu_res;
            zero_q <= (alu_res == '0);
         end
         if (done)
            last_q <= gid_q;
      end
   end

`ifdef ALU_SHARE_ARB_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (state == ST_EXEC)
         ovf_q <= ((ctrl_q == CTRL_ADD) || (ctrl_q == CTRL_SUB)) && ovf;
   end

   assign bus.rsp_ovf_o = ovf_q;
`endif

   assign bus.rsp_result_o = res_q;
   assign bus.rsp_zero_o   = zero_q;
   assign bus.busy_o       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized self-checking bench for alu_share_arb against
// an arithmetic reference model with a round-robin pointer.
module tb_alu_share_arb;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   rr_last = 1'b1;

   alu_share_arb_if #(.N_REQ(2), .W(32)) bus ();

   alu_share_arb #(.N_REQ(2), .W(32)) dut (
      .clk_i (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void ref_alu(input logic [3:0] c,
                                   input logic [31:0] a, b,
                                   output logic [31:0] r,
                                   output logic ov);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint t;
      ov = 1'b0;
      r  = 32'h0;
      case (c)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin
            r = a + b; t = sa + sb;
            ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'b0110: begin
            r = a - b; t = sa - sb;
            ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b1100: r = ~(a | b);
         default: r = 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [3:0] rnd_ctrl();
      logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010,
                                4'b0110, 4'b0111, 4'b1100};
      if ($urandom_range(0, 7) == 0) return 4'($urandom);
      return codes[$urandom_range(0, 5)];
   endfunction

   task automatic drive_req(input int id, input logic [3:0] c,
                            input logic [31:0] a, b);
      bus.req_ctrl_i[id]  = c;
      bus.req_src1_i[id]  = a;
      bus.req_src2_i[id]  = b;
      bus.req_valid_i[id] = 1'b1;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk); #1;
         if (bus.rsp_valid_o != 2'b00) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic xact(input int id, input logic [3:0] c,
                       input logic [31:0] a, b,
                       output bit acc, output int lat,
                       output logic [1:0] rv, output logic [31:0] r,
                       output logic z, output logic ov);
      acc = 0; lat = 0; rv = 0; r = 0; z = 0; ov = 0;
      @(negedge clk);
      drive_req(id, c, a, b);
      for (int i = 0; i < 10; i++) begin
         #1;
         if (bus.req_ready_o[id]) begin
            acc = 1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      bus.req_valid_i[id] = 1'b0;
      if (!acc) return;
      wait_rsp(lat);
      rv = bus.rsp_valid_o;
      r  = bus.rsp_result_o;
      z  = bus.rsp_zero_o;
`ifdef ALU_SHARE_ARB_OVF_EN
      ov = bus.rsp_ovf_o;
`endif
      bus.rsp_ready_i[id] = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i[id] = 1'b0;
      rr_last = id[0];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid_i = '0;
      bus.rsp_ready_i = '0;
      bus.req_ctrl_i  = '0;
      bus.req_src1_i  = '0;
      bus.req_src2_i  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid_o); end
      n_cmp++; if (bus.rsp_result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.rsp_result_o); end
      n_cmp++; if (bus.rsp_zero_o !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b want 0", bus.rsp_zero_o); end
      rst_n = 1'b1;
      rr_last = 1'b1;
   endtask

   task automatic test_add();
      bit acc; int lat; logic [1:0] rv; logic [31:0] r; logic z, ov;
      xact(0, 4'b0010, 32'd5, 32'd7, acc, lat, rv, r, z, ov);
      n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL add_accept: got %b want 1", acc); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL add_latency: got %0d want 2", lat); end
      n_cmp++; if (rv !== 2'b01) begin n_bad++; $display("FAIL add_rsp_valid: got %b want 01", rv); end
      n_cmp++; if (r !== 32'd12) begin n_bad++; $display("FAIL add_result: got %h want %h", r, 32'd12); end
      n_cmp++; if (z !== 1'b0) begin n_bad++; $display("FAIL add_zero: got %b want 0", z); end
   endtask

   task automatic test_rr_reset_exit();
      int lat;
      rst_n = 1'b0;
      drive_req(0, 4'b0110, 32'd3, 32'd3);
      drive_req(1, 4'b0001, 32'hF0, 32'h0F);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rr_last = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_bad++; $display("FAIL rr_first_ready: got %b want 01", bus.req_ready_o); end
      @(posedge clk); #1;
      bus.req_valid_i[0] = 1'b0;
      wait_rsp(lat);
      n_cmp++; if (bus.rsp_valid_o !== 2'b01) begin n_bad++; $display("FAIL rr_first_rsp: got %b want 01", bus.rsp_valid_o); end
      n_cmp++; if (bus.rsp_result_o !== 32'h0) begin n_bad++; $display("FAIL rr_sub_result: got %h want 0", bus.rsp_result_o); end
      n_cmp++; if (bus.rsp_zero_o !== 1'b1) begin n_bad++; $display("FAIL rr_sub_zero: got %b want 1", bus.rsp_zero_o); end
      bus.rsp_ready_i[0] = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i[0] = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_bad++; $display("FAIL rr_second_ready: got %b want 10", bus.req_ready_o); end
      @(posedge clk); #1;
      bus.req_valid_i[1] = 1'b0;
      wait_rsp(lat);
      n_cmp++; if (bus.rsp_valid_o !== 2'b10) begin n_bad++; $display("FAIL rr_second_rsp: got %b want 10", bus.rsp_valid_o); end
      n_cmp++; if (bus.rsp_result_o !== 32'hFF) begin n_bad++; $display("FAIL rr_or_result: got %h want ff", bus.rsp_result_o); end
      bus.rsp_ready_i[1] = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i[1] = 1'b0;
      rr_last = 1'b1;
   endtask

   task automatic test_slt();
      bit acc; int lat; logic [1:0] rv; logic [31:0] r; logic z, ov;
      xact(0, 4'b0111, 32'hFFFF_FFFF, 32'd1, acc, lat, rv, r, z, ov);
      n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL slt_neg_lt_pos: got %h want 1", r); end
      xact(0, 4'b0111, 32'd1, 32'hFFFF_FFFF, acc, lat, rv, r, z, ov);
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL slt_pos_lt_neg: got %h want 0", r); end
      xact(1, 4'b1111, 32'h1234, 32'h5678, acc, lat, rv, r, z, ov);
      n_cmp++; if (r !== 32'd0 || z !== 1'b1) begin n_bad++; $display("FAIL unlisted_ctrl: got %h/%b want 0/1", r, z); end
      xact(0, 4'b1100, 32'h0F0F_0000, 32'h0000_00FF, acc, lat, rv, r, z, ov);
      n_cmp++; if (r !== 32'hF0F0_FF00) begin n_bad++; $display("FAIL nor_result: got %h want f0f0ff00", r); end
   endtask

   task automatic test_stall();
      int lat;
      logic [31:0] hold;
      @(negedge clk);
      drive_req(0, 4'b0010, 32'h1111_0000, 32'h0000_2222);
      #1;
      n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_bad++; $display("FAIL stall_ready: got %b want 01", bus.req_ready_o); end
      @(posedge clk); #1;
      bus.req_valid_i[0] = 1'b0;
      drive_req(1, 4'b0001, 32'h1, 32'h2);
      wait_rsp(lat);
      hold = 32'h1111_2222;
      bus.rsp_ready_i[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (bus.rsp_valid_o !== 2'b01) begin n_bad++; $display("FAIL stall_rsp_valid[%0d]: got %b want 01", i, bus.rsp_valid_o); end
         n_cmp++; if (bus.rsp_result_o !== hold) begin n_bad++; $display("FAIL stall_result[%0d]: got %h want %h", i, bus.rsp_result_o, hold); end
         n_cmp++; if (bus.req_ready_o !== 2'b00) begin n_bad++; $display("FAIL stall_req_ready[%0d]: got %b want 00", i, bus.req_ready_o); end
         n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL stall_busy[%0d]: got %b want 1", i, bus.busy_o); end
         @(negedge clk); #1;
      end
      bus.rsp_ready_i = 2'b01;
      @(posedge clk); #1;
      bus.rsp_ready_i = 2'b00;
      bus.req_valid_i = 2'b00;
      rr_last = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL stall_release_busy: got %b want 0", bus.busy_o); end
   endtask

   task automatic test_reset_exec();
      bit seen = 0;
      @(negedge clk);
      drive_req(0, 4'b0010, 32'd9, 32'd9);
      @(posedge clk); #1;
      bus.req_valid_i[0] = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rexec_busy: got %b want 0", bus.busy_o); end
      n_cmp++; if (bus.rsp_valid_o !== 2'b00) begin n_bad++; $display("FAIL rexec_rsp_valid: got %b want 00", bus.rsp_valid_o); end
      n_cmp++; if (bus.rsp_result_o !== 32'h0) begin n_bad++; $display("FAIL rexec_result: got %h want 0", bus.rsp_result_o); end
      rst_n = 1'b1;
      rr_last = 1'b1;
      bus.rsp_ready_i = 2'b11;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (bus.rsp_valid_o != 2'b00) seen = 1;
      end
      bus.rsp_ready_i = 2'b00;
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rexec_no_rsp: got %b want 0", seen); end
      drive_req(0, 4'b0000, 32'h0, 32'h0);
      drive_req(1, 4'b0000, 32'h0, 32'h0);
      #1;
      n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_bad++; $display("FAIL rexec_ptr: got %b want 01", bus.req_ready_o); end
      bus.req_valid_i = 2'b00;
   endtask

   task automatic test_random();
      logic [3:0]  c [2];
      logic [31:0] a [2];
      logic [31:0] b [2];
      logic [31:0] er, hold;
      logic        eov;
      logic [1:0]  erdy;
      int v, g, lat, stall;
      for (int it = 0; it < 150; it++) begin
         @(negedge clk);
         v = $urandom_range(0, 3);
         for (int k = 0; k < 2; k++) begin
            c[k] = rnd_ctrl(); a[k] = rnd_val(); b[k] = rnd_val();
            drive_req(k, c[k], a[k], b[k]);
            bus.req_valid_i[k] = v[k];
         end
         bus.rsp_ready_i = 2'b00;
         #1;
         g = (v == 3) ? (rr_last ? 0 : 1) : ((v == 2) ? 1 : 0);
         erdy = (v == 0) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
         n_cmp++; if (bus.req_ready_o !== erdy) begin n_bad++; $display("FAIL rnd_grant[%0d]: got %b want %b", it, bus.req_ready_o, erdy); end
         if (v == 0) continue;
         @(posedge clk); #1;
         bus.req_valid_i = 2'b00;
         ref_alu(c[g], a[g], b[g], er, eov);
         wait_rsp(lat);
         n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 2", it, lat); end
         n_cmp++; if (bus.rsp_valid_o !== erdy) begin n_bad++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", it, bus.rsp_valid_o, erdy); end
         n_cmp++; if (bus.rsp_result_o !== er) begin n_bad++; $display("FAIL rnd_result[%0d]: ctrl %b a %h b %h got %h want %h", it, c[g], a[g], b[g], bus.rsp_result_o, er); end
         n_cmp++; if (bus.rsp_zero_o !== (er == 32'h0)) begin n_bad++; $display("FAIL rnd_zero[%0d]: got %b want %b", it, bus.rsp_zero_o, er == 32'h0); end
`ifdef ALU_SHARE_ARB_OVF_EN
         n_cmp++; if (bus.rsp_ovf_o !== eov) begin n_bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", it, bus.rsp_ovf_o, eov); end
`endif
         hold = er;
         stall = $urandom_range(0, 3);
         bus.rsp_ready_i[1-g] = 1'b1;
         repeat (stall) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.rsp_valid_o !== erdy || bus.rsp_result_o !== hold) begin n_bad++; $display("FAIL rnd_hold[%0d]: got %b/%h want %b/%h", it, bus.rsp_valid_o, bus.rsp_result_o, erdy, hold); end
         end
         bus.rsp_ready_i[g] = 1'b1;
         @(posedge clk); #1;
         bus.rsp_ready_i = 2'b00;
         rr_last = g[0];
      end
   endtask

`ifdef ALU_SHARE_ARB_OVF_EN
   task automatic test_ovf();
      bit acc; int lat; logic [1:0] rv; logic [31:0] r; logic z, ov;
      xact(0, 4'b0010, 32'h7FFF_FFFF, 32'd1, acc, lat, rv, r, z, ov);
      n_cmp++; if (r !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_result: got %h want 80000000", r); end
      n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ov); end
      xact(1, 4'b0010, 32'd1, 32'd1, acc, lat, rv, r, z, ov);
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", ov); end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_rr_reset_exit();
      test_slt();
      test_stall();
      test_reset_exec();
`ifdef ALU_SHARE_ARB_OVF_EN
      test_ovf();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
